uart_receiver: RTL and testbench

Serial-to-parallel UART receive engine with 16x oversampling, optional parity and framing check. Sits directly upstream of the UART status register: its `recv_data`, `recv_int`, `recv_error` and `recv_busy` outputs drive that register's same-named inputs one-to-one. Format is 8N1 or 8E1/8O1, LSB first, one stop bit.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_baud_tick.sv | 18 +
 rtl/uart_receiver.sv | 115 +++++++++++
 tb/tb_uart_receiver.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the receive and transmit engines
package uart_pkg;
   localparam int OVERSAMPLE_DEFAULT = 16;
   localparam int UART_DATA_W = 8;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: loadable down-counter producing one tick every div+1 clk cycles
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   logic [DIV_W-1:0] cnt;
   assign tick = (cnt == '0);
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (load || tick) cnt <= div;
      else cnt <= cnt - 1'b1;
   end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled UART receive engine with optional parity and framing check
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
   parameter int DIV_W      = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx,
   input  logic [DIV_W-1:0]       baud_div,
   input  logic                   parity_en,
   input  logic                   parity_odd,
   output logic [UART_DATA_W-1:0] recv_data,
   output logic                   recv_int,
   output logic                   recv_error,
   output logic                   recv_busy
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(UART_DATA_W);
   rx_state_t state, state_n;
   logic rx_meta, rx_sync, rx_prev;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [BW-1:0] bcnt, bcnt_n;
   logic [UART_DATA_W-1:0] shreg, shreg_n, data_n;
   logic [DIV_W-1:0] div_q, div_n;
   logic perr, perr_n, int_n, err_n, pen_q, pen_n, podd_q, podd_n;
   logic load, tick, sample;
   uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
      .clk (clk),
      .rst (rst),
      .load(load),
      .div (load ? baud_div : div_q),
      .tick(tick)
   );
   always_ff @(posedge clk) begin
      if (rst) {rx_meta, rx_sync, rx_prev} <= 3'b111;
      else {rx_meta, rx_sync, rx_prev} <= {rx, rx_meta, rx_sync};
   end
   assign recv_busy = (state != RX_IDLE);
   // START samples at mid-bit; every later sample is one full bit period after the previous one
   always_comb begin
      state_n = state;
      tcnt_n  = tcnt;
      bcnt_n  = bcnt;
      shreg_n = shreg;
      perr_n  = perr;
      data_n  = recv_data;
      int_n   = 1'b0;
      err_n   = 1'b0;
      div_n   = div_q;
      pen_n   = pen_q;
      podd_n  = podd_q;
      load    = 1'b0;
      sample  = tick && (state == RX_START ? tcnt == TW'(OVERSAMPLE/2-1) : tcnt == TW'(OVERSAMPLE-1));
      if (tick) tcnt_n = sample ? '0 : tcnt + 1'b1;
      case (state)
         RX_IDLE: if (!rx_sync && rx_prev) begin
            state_n = RX_START;
            load    = 1'b1;
            tcnt_n  = '0;
            bcnt_n  = '0;
            perr_n  = 1'b0;
            div_n   = baud_div;
            pen_n   = parity_en;
            podd_n  = parity_odd;
         end
         RX_START: if (sample) state_n = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA: if (sample) begin
            shreg_n = {rx_sync, shreg[UART_DATA_W-1:1]};
            bcnt_n  = bcnt + 1'b1;
            if (bcnt == BW'(UART_DATA_W-1)) state_n = pen_q ? RX_PARITY : RX_STOP;
         end
         RX_PARITY: if (sample) begin
            perr_n  = (^shreg ^ rx_sync) != podd_q;
            state_n = RX_STOP;
         end
         // return to IDLE mid-stop-bit so a back-to-back start edge is not missed
         RX_STOP: if (sample) begin
            state_n = RX_IDLE;
            int_n   = rx_sync && !perr;
            err_n   = !(rx_sync && !perr);
            data_n  = (rx_sync && !perr) ? shreg : recv_data;
         end
         default: state_n = RX_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RX_IDLE;
         tcnt       <= '0;
         bcnt       <= '0;
         shreg      <= '0;
         perr       <= 1'b0;
         recv_data  <= '0;
         recv_int   <= 1'b0;
         recv_error <= 1'b0;
         div_q      <= '0;
         pen_q      <= 1'b0;
         podd_q     <= 1'b0;
      end else begin
         state      <= state_n;
         tcnt       <= tcnt_n;
         bcnt       <= bcnt_n;
         shreg      <= shreg_n;
         perr       <= perr_n;
         recv_data  <= data_n;
         recv_int   <= int_n;
         recv_error <= err_n;
         div_q      <= div_n;
         pen_q      <= pen_n;
         podd_q     <= podd_n;
      end
   end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized and directed frame checks against a bit-level line model
module tb_uart_receiver;
   logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
   logic [15:0] baud_div = 16'd3;
   logic parity_en = 1'b0, parity_odd = 1'b0;
   logic [7:0] recv_data;
   logic recv_int, recv_error, recv_busy;
   int cyc = 0, n_int = 0, n_err = 0, t_int = -1, t_err = -1;
   int checks = 0, failures = 0;
   bit busy_seen = 1'b0;
   logic [7:0] exp_data = 8'h00;
   uart_receiver dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .baud_div  (baud_div),
      .parity_en (parity_en),
      .parity_odd(parity_odd),
      .recv_data (recv_data),
      .recv_int  (recv_int),
      .recv_error(recv_error),
      .recv_busy (recv_busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask
   always @(posedge clk) begin
      #1;
      if (recv_int) begin n_int++; t_int = cyc; end
      if (recv_error) begin n_err++; t_err = cyc; end
      if (recv_int || recv_error) check("int_err_exclusive", 32'(recv_int & recv_error), 0);
      if (recv_busy) busy_seen = 1'b1;
   end
   task automatic send_frame(input logic [7:0] b, input int d, input bit pen, input bit pbit,
                             input bit stop, input int new_div);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      if (pen) bits.push_back(pbit);
      bits.push_back(stop);
      for (int i = 0; i < bits.size(); i++) begin
         rx = bits[i];
         if (i == 1 && new_div >= 0) baud_div = 16'(new_div);
         repeat (16 * d) @(posedge clk);
         #1;
      end
   endtask
   task automatic run_frame(input logic [7:0] b, input int d, input bit pen, input bit podd,
                            input bit pbit, input bit stop, input int new_div);
      int i0, e0, t_exp;
      bit good;
      baud_div   = 16'(d - 1);
      parity_en  = pen;
      parity_odd = podd;
      good  = stop && (!pen || ((($countones(b) + pbit) % 2) == (podd ? 1 : 0)));
      i0    = n_int;
      e0    = n_err;
      t_exp = cyc + 3 + (pen ? 168 : 152) * d;
      send_frame(b, d, pen, pbit, stop, new_div);
      if (good) exp_data = b;
      check("int_count", n_int - i0, 32'(good));
      check("err_count", n_err - e0, 32'(!good));
      check("pulse_time", good ? t_int : t_err, t_exp);
      check("data", 32'(recv_data), 32'(exp_data));
      check("busy_idle", 32'(recv_busy), 0);
   endtask
   initial begin
      int i0, e0, d;
      logic [7:0] b;
      bit pen, podd, pbit, stop;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_data", 32'(recv_data), 0);
      check("rst_int", 32'(recv_int), 0);
      check("rst_err", 32'(recv_error), 0);
      check("rst_busy", 32'(recv_busy), 0);
      run_frame(8'hA5, 4, 0, 0, 0, 1, -1);
      busy_seen = 1'b0;
      i0 = n_int;
      e0 = n_err;
      rx = 1'b0;
      repeat (16) @(posedge clk);
      #1 rx = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      check("false_busy_seen", 32'(busy_seen), 1);
      check("false_int", n_int - i0, 0);
      check("false_err", n_err - e0, 0);
      check("false_data", 32'(recv_data), 32'h A5);
      check("false_busy_idle", 32'(recv_busy), 0);
      run_frame(8'h3C, 4, 0, 0, 0, 0, -1);
      e0 = n_err;
      repeat (2000) @(posedge clk);
      #1;
      check("break_no_repeat", n_err - e0, 0);
      check("break_busy", 32'(recv_busy), 0);
      rx = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      run_frame(8'h01, 2, 1, 0, 1, 1, -1);
      run_frame(8'h01, 2, 1, 0, 0, 1, -1);
      run_frame(8'h01, 2, 1, 1, 0, 1, -1);
      run_frame(8'h01, 2, 1, 1, 1, 1, -1);
      run_frame(8'h55, 4, 0, 0, 0, 1, 7);
      run_frame(8'hAA, 8, 0, 0, 0, 1, -1);
      baud_div = 16'd3;
      parity_en = 1'b0;
      i0 = n_int;
      e0 = n_err;
      fork
         send_frame(8'hFF, 4, 0, 0, 1, -1);
         begin
            repeat (16 * 4 * 3) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            check("midrst_data", 32'(recv_data), 0);
            check("midrst_int", 32'(recv_int), 0);
            check("midrst_err", 32'(recv_error), 0);
            check("midrst_busy", 32'(recv_busy), 0);
         end
      join
      exp_data = 8'h00;
      check("midrst_no_int", n_int - i0, 0);
      check("midrst_no_err", n_err - e0, 0);
      run_frame(8'h81, 4, 0, 0, 0, 1, -1);
      for (int k = 0; k < 10; k++) begin
         b    = 8'($urandom);
         d    = $urandom_range(1, 4);
         pen  = 1'($urandom_range(0, 1));
         podd = 1'($urandom_range(0, 1));
         pbit = 1'($countones(b) % 2) ^ podd;
         if ($urandom_range(0, 3) == 0) pbit = ~pbit;
         stop = ($urandom_range(0, 6) != 0);
         run_frame(b, d, pen, podd, pbit, stop, -1);
         if (!stop) begin
            rx = 1'b1;
            repeat (8) @(posedge clk);
            #1;
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
